// File: rtl/imem_stream_loader_if.sv
// Bus bundle for imem_stream_loader: boot byte stream (load side) and
// instruction fetch port. The master side is the loader/fetch client,
// the slave side is the instruction memory.
interface imem_stream_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  load_start;
  logic [ADDR_WIDTH:0]   load_length;
  logic [7:0]            load_byte;
  logic                  load_valid;
  logic                  load_ready;
  logic                  load_done;
  logic                  load_error;
  logic [DATA_WIDTH-1:0] load_checksum;
  logic                  busy;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_valid;

  modport master (
    output load_start, load_length, load_byte, load_valid, fetch_en, fetch_addr,
    input  load_ready, load_done, load_error, load_checksum, busy,
           fetch_data, fetch_valid
  );

  modport slave (
    input  load_start, load_length, load_byte, load_valid, fetch_en, fetch_addr,
    output load_ready, load_done, load_error, load_checksum, busy,
           fetch_data, fetch_valid
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Instruction memory loaded at boot from a byte stream, then serving
// 1-cycle-latency fetches. A RUN/LOAD/WRITE/DONE state machine keeps the
// fetch port blocked until the whole program has been written.
// Optional macro IMEM_LOAD_CHECKSUM_EN: running sum of written words on
// load_checksum; when undefined load_checksum is tied to zero.
module imem_stream_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16000
) (
  input logic                 clk,
  input logic                 reset,
  imem_stream_loader_if.slave bus
);

  localparam int unsigned           BYTES     = DATA_WIDTH / 8;
  localparam int                    BCW       = $clog2(BYTES + 1);
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {RUN, LOAD, WRITE, DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [BCW-1:0]        r_bcnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_load_ready;
  logic                  r_busy;
  logic                  r_load_done;
  logic                  r_load_error;
  logic                  r_fetch_valid;
  logic                  r_fetch_zero;
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_len_ok;
  logic w_start;
  logic w_fetch;
  logic w_fetch_in_range;
  logic w_accept;

  assign w_len_ok         = (bus.load_length != '0) && (bus.load_length <= DEPTH_L);
  assign w_start          = (r_state == RUN) && bus.load_start && w_len_ok;
  assign w_fetch          = (r_state == RUN) && bus.fetch_en;
  assign w_fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_L;
  assign w_accept         = (r_state == LOAD) && bus.load_valid && r_load_ready;

  // Control FSM with registered handshake, status and fetch-valid outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_len         <= '0;
      r_wptr        <= '0;
      r_bcnt        <= '0;
      r_word        <= '0;
      r_load_ready  <= 1'b0;
      r_busy        <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_error  <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_zero  <= 1'b1;
    end else begin
      r_load_done   <= 1'b0;
      r_load_error  <= 1'b0;
      r_fetch_valid <= 1'b0;
      case (r_state)
        RUN: begin
          r_fetch_valid <= bus.fetch_en;
          if (bus.fetch_en) begin
            r_fetch_zero <= !w_fetch_in_range;
          end
          if (bus.load_start) begin
            if (w_len_ok) begin
              r_state      <= LOAD;
              r_len        <= bus.load_length;
              r_wptr       <= '0;
              r_bcnt       <= '0;
              r_busy       <= 1'b1;
              r_load_ready <= 1'b1;
            end else begin
              r_load_error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_word <= (r_word << 8) | DATA_WIDTH'(bus.load_byte);
            r_bcnt <= r_bcnt + 1'b1;
            if (r_bcnt == LAST_BYTE) begin
              r_state      <= WRITE;
              r_load_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          r_wptr <= r_wptr + 1'b1;
          r_bcnt <= '0;
          if ((r_wptr + 1'b1) == r_len) begin
            r_state     <= DONE;
            r_load_done <= 1'b1;
          end else begin
            r_state      <= LOAD;
            r_load_ready <= 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Storage array: word write in WRITE, enabled synchronous read in RUN
  always_ff @(posedge clk) begin
    if (r_state == WRITE) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= r_word;
    end
    if (w_fetch && w_fetch_in_range) begin
      r_ram_q <= r_mem[bus.fetch_addr];
    end
  end

  // Out-of-range fetches and reset read as NOP without touching the RAM port
  assign bus.fetch_data  = r_fetch_zero ? '0 : r_ram_q;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.load_ready  = r_load_ready;
  assign bus.load_done   = r_load_done;
  assign bus.load_error  = r_load_error;
  assign bus.busy        = r_busy;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running sum of written words, cleared on an accepted load start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum + r_word;
    end
  end

  assign bus.load_checksum = r_checksum;
`else
  assign bus.load_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed testbench for imem_stream_loader: boot load, rejection,
// stalls, fetch blocking, reset mid-load, checksum and overlap cases.
module tb_imem_stream_loader;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int DP = 16000;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_count;

  imem_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  imem_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.load_done === 1'b1) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    bus.load_start  = 1'b1;
    bus.load_length = (AW + 1)'(len);
    tick();
    bus.load_start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.load_byte  = b;
    bus.load_valid = 1'b1;
    while (bus.load_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_ready: load_ready=%b required 1", bus.load_ready);
    end
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8]);
  endtask

  task automatic finish_load();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL finish_load: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = a;
    tick();
    bus.fetch_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.fetch_valid, bus.load_ready, bus.busy, bus.load_done, bus.load_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.fetch_valid, bus.load_ready, bus.busy, bus.load_done, bus.load_error});
    end
    checks++;
    if (bus.fetch_data !== 32'h0 || bus.load_checksum !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: fetch_data=%h checksum=%h required 0", bus.fetch_data, bus.load_checksum);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int d0;
    d0 = done_count;
    start_load(2);
    checks++;
    if (bus.busy !== 1'b1 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: busy=%b ready=%b required 1 1", bus.busy, bus.load_ready);
    end
    send_word(32'h12345678);
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_write_ready: load_ready=%b required 0", bus.load_ready);
    end
    send_word(32'h9ABCDEF0);
    tick();
    checks++;
    if (bus.load_done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b required 1 1", bus.load_done, bus.busy);
    end
    checks++;
    if (bus.load_checksum !== (CK_EN ? 32'hACF13568 : 32'h0)) begin
      errors++;
      $display("FAIL basic_checksum: got %h required %h", bus.load_checksum, CK_EN ? 32'hACF13568 : 32'h0);
    end
    tick();
    checks++;
    if (bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done: done=%b busy=%b required 0 0", bus.load_done, bus.busy);
    end
    fetch(0);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_fetch0: valid=%b data=%h required 1 12345678", bus.fetch_valid, bus.fetch_data);
    end
    fetch(1);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL basic_fetch1: valid=%b data=%h required 1 9abcdef0", bus.fetch_valid, bus.fetch_data);
    end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_data !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL fetch_hold: valid=%b data=%h required 0 9abcdef0", bus.fetch_valid, bus.fetch_data);
    end
    fetch(14'd16000);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL fetch_oob: valid=%b data=%h required 1 00000000", bus.fetch_valid, bus.fetch_data);
    end
    checks++;
    if (done_count - d0 !== 1) begin
      errors++;
      $display("FAIL basic_done_pulses: got %0d required 1", done_count - d0);
    end
  endtask

  task automatic test_rejected();
    int lens[2];
    lens[0] = 0;
    lens[1] = DP + 1;
    for (int i = 0; i < 2; i++) begin
      start_load(lens[i]);
      checks++;
      if (bus.load_error !== 1'b1 || bus.busy !== 1'b0 || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL reject_len%0d: error=%b busy=%b ready=%b required 1 0 0",
                 lens[i], bus.load_error, bus.busy, bus.load_ready);
      end
      tick();
      checks++;
      if (bus.load_error !== 1'b0) begin
        errors++;
        $display("FAIL reject_pulse_len%0d: error=%b required 0", lens[i], bus.load_error);
      end
    end
    fetch(0);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h12345678) begin
      errors++;
      $display("FAIL reject_still_run: valid=%b data=%h required 1 12345678", bus.fetch_valid, bus.fetch_data);
    end
    start_load(DP);
    checks++;
    if (bus.busy !== 1'b1 || bus.load_error !== 1'b0) begin
      errors++;
      $display("FAIL accept_depth: busy=%b error=%b required 1 0", bus.busy, bus.load_error);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stalls();
    logic [31:0] w;
    w = 32'hAABBCCDD;
    start_load(1);
    for (int unsigned i = 0; i < 4; i++) begin
      send_byte(w[31 - 8*i -: 8]);
      if (i < 3) begin
        checks++;
        if (bus.load_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall_gap_ready%0d: load_ready=%b required 1", i, bus.load_ready);
        end
        tick();
      end
    end
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_write_ready: load_ready=%b required 0", bus.load_ready);
    end
    finish_load();
    fetch(0);
    checks++;
    if (bus.fetch_data !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL stall_word: data=%h required aabbccdd", bus.fetch_data);
    end
    fetch(1);
    checks++;
    if (bus.fetch_data !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL stall_word1_kept: data=%h required 9abcdef0", bus.fetch_data);
    end
  endtask

  task automatic test_fetch_blocked();
    logic [31:0] w;
    logic        acc;
    int          idx;
    w = 32'h01020304;
    start_load(1);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 14'd1;
    idx            = 0;
    bus.load_byte  = w[31:24];
    bus.load_valid = 1'b1;
    for (int c = 0; c < 30 && bus.busy === 1'b1; c++) begin
      acc = bus.load_ready && bus.load_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) bus.load_byte = w[31 - 8*idx -: 8];
        else bus.load_valid = 1'b0;
      end
      if (bus.busy === 1'b1) begin
        checks++;
        if (bus.fetch_valid !== 1'b0) begin
          errors++;
          $display("FAIL blocked_cycle%0d: fetch_valid=%b required 0", c, bus.fetch_valid);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL blocked_return: busy=%b valid=%b required 0 0", bus.busy, bus.fetch_valid);
    end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL blocked_resume: valid=%b data=%h required 1 9abcdef0", bus.fetch_valid, bus.fetch_data);
    end
    fetch(0);
    checks++;
    if (bus.fetch_data !== 32'h01020304) begin
      errors++;
      $display("FAIL blocked_word: data=%h required 01020304", bus.fetch_data);
    end
  endtask

  task automatic test_reset_mid_load();
    start_load(2);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.load_ready, bus.fetch_valid, bus.load_done} !== 4'b0 ||
        bus.fetch_data !== 32'h0 || bus.load_checksum !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b data=%h cks=%h required 0000 0 0",
               {bus.busy, bus.load_ready, bus.fetch_valid, bus.load_done}, bus.fetch_data, bus.load_checksum);
    end
    tick();
    reset = 1'b0;
    tick();
    fetch(0);
    checks++;
    if (bus.fetch_data !== 32'h11223344) begin
      errors++;
      $display("FAIL midreset_word0: data=%h required 11223344", bus.fetch_data);
    end
    fetch(1);
    checks++;
    if (bus.fetch_data !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL midreset_word1: data=%h required 9abcdef0", bus.fetch_data);
    end
    start_load(2);
    send_word(32'h0BADF00D);
    send_word(32'h13579BDF);
    finish_load();
    fetch(0);
    checks++;
    if (bus.fetch_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL reload_word0: data=%h required 0badf00d", bus.fetch_data);
    end
    fetch(1);
    checks++;
    if (bus.fetch_data !== 32'h13579BDF) begin
      errors++;
      $display("FAIL reload_word1: data=%h required 13579bdf", bus.fetch_data);
    end
  endtask

  task automatic test_checksum();
    start_load(2);
    send_word(32'h00000001);
    send_word(32'hFFFFFFFF);
    tick();
    checks++;
    if (bus.load_done !== 1'b1 || bus.load_checksum !== 32'h0) begin
      errors++;
      $display("FAIL checksum_wrap: done=%b cks=%h required 1 00000000", bus.load_done, bus.load_checksum);
    end
    finish_load();
    fetch(1);
    checks++;
    if (bus.fetch_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL checksum_word1: data=%h required ffffffff", bus.fetch_data);
    end
  endtask

  task automatic test_back_to_back();
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 14'd1;
    start_load(1);
    bus.fetch_en   = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hFFFFFFFF || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL overlap_fetch: valid=%b data=%h busy=%b required 1 ffffffff 1",
               bus.fetch_valid, bus.fetch_data, bus.busy);
    end
    send_word(32'hCAFEBABE);
    finish_load();
    checks++;
    if (bus.load_checksum !== (CK_EN ? 32'hCAFEBABE : 32'h0)) begin
      errors++;
      $display("FAIL overlap_checksum: got %h required %h", bus.load_checksum, CK_EN ? 32'hCAFEBABE : 32'h0);
    end
    fetch(0);
    checks++;
    if (bus.fetch_data !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL overlap_word: data=%h required cafebabe", bus.fetch_data);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    done_count      = 0;
    reset           = 1'b1;
    bus.load_start  = 1'b0;
    bus.load_length = '0;
    bus.load_byte   = '0;
    bus.load_valid  = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.fetch_addr  = '0;
    test_reset();
    test_basic_load();
    test_rejected();
    test_stalls();
    test_fetch_blocked();
    test_reset_mid_load();
    test_checksum();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
Parametrised instruction memory. It is loaded at boot from a byte stream (UART receiver side) through a valid/ready handshake, then serves synchronous instruction fetches with 1-cycle latency. A small state machine arbitrates between load mode and run mode, so the core never sees a half-written program. It sits between the serial loader and the fetch stage of the core.

Parameters:
DATA_WIDTH, 32, instruction word width; must be a multiple of 8
ADDR_WIDTH, 14, fetch/write address width in words
DEPTH, 16000, number of words implemented; must satisfy DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
load_start  in  1  pulse: begin a program load
load_length  in  ADDR_WIDTH+1  number of words to load; sampled when load_start is accepted
load_byte  in  8  stream byte
load_valid  in  1  load_byte is valid
load_ready  out  1  block accepts load_byte this cycle
load_done  out  1  1-cycle pulse after the last word is written
load_error  out  1  1-cycle pulse: load_start rejected
load_checksum  out  DATA_WIDTH  word checksum (optional feature)
busy  out  1  high while a load is in progress
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_WIDTH  word address
fetch_data  out  DATA_WIDTH  fetched instruction
fetch_valid  out  1  fetch_data is valid this cycle

Behaviour:
- Reset (asynchronous, active-high): state=RUN. fetch_data=0, fetch_valid=0, load_ready=0, busy=0, load_done=0, load_error=0, load_checksum=0, write pointer=0, byte counter=0. RAM contents are not cleared.
- States: RUN, LOAD, WRITE, DONE.
- RUN:
  - fetch_en=1 -> next cycle fetch_valid=1 and fetch_data=RAM[fetch_addr].
  - If fetch_addr >= DEPTH, fetch_data=0 (NOP) and fetch_valid=1.
  - fetch_en=0 -> next cycle fetch_valid=0; fetch_data holds its last value.
  - load_start with 1 <= load_length <= DEPTH -> LOAD. Latch the length, clear the write pointer and byte counter, busy=1.
  - load_start with load_length=0 or >DEPTH -> stay in RUN, load_error=1 for one cycle.
  - load_start and fetch_en in the same cycle: the fetch is served and the load starts next cycle.
- LOAD:
  - load_ready=1. Each cycle with load_valid&&load_ready, shift load_byte in MSB-first (first byte -> bits [DATA_WIDTH-1:DATA_WIDTH-8]) and increment the byte counter.
  - When the byte counter reaches DATA_WIDTH/8 -> WRITE.
  - load_valid gaps of any length are legal.
- WRITE (1 cycle):
  - load_ready=0.
  - RAM[wptr] <= assembled word; wptr++; byte counter=0.
  - If the new wptr == latched length -> DONE, else -> LOAD.
- DONE (1 cycle): load_done=1, busy=0 next cycle, then -> RUN.
- While busy=1:
  - fetch_en is ignored and fetch_valid=0.
  - load_start is ignored; no load_error is raised.
- Throughput: a 32-bit word costs 4 accepted bytes plus 1 WRITE cycle.
- Reset mid-load: returns to RUN immediately. Words already written stay in RAM; the partial word is discarded.
- load_length width allows the value DEPTH itself. Wrap-around of wptr cannot occur because the length is checked at start.

Optional Feature:
IMEM_LOAD_CHECKSUM_EN.
- Defined: load_checksum is cleared on an accepted load_start. Each WRITE adds the written word to it (mod 2**DATA_WIDTH). The final sum is stable from the load_done cycle until the next accepted load_start.
- Not defined: load_checksum is constant 0 and no adder is built.

Test Plan:
- Basic load: reset, load_start with length=2, bytes 12 34 56 78 9A BC DE F0 -> load_done pulses once; fetch addr 0 -> 0x12345678 one cycle later with fetch_valid=1; fetch addr 1 -> 0x9ABCDEF0.
- Rejected loads: load_start with length=0 and with length=16001 -> one-cycle load_error each; busy stays 0; state stays RUN.
- Handshake stalls: load_valid toggling every other cycle, length=1, bytes AA BB CC DD -> word 0xAABBCCDD. load_ready=0 in the WRITE cycle, and no byte is lost.
- Fetch blocked during load: fetch_en held at 1 through a load -> fetch_valid=0 while busy=1; it resumes on the cycle after return to RUN.
- Reset mid-load: assert reset after 6 of 8 bytes -> outputs return to reset values immediately; word 0 is retained, word 1 is unwritten; a new load then succeeds.
- Checksum (macro defined): load words 0x00000001 and 0xFFFFFFFF -> load_checksum=0x00000000 at load_done. Without the macro, load_checksum stays 0.
